// File: rtl/gfx_cmd_decode_engine_if.sv
// gfx_cmd_decode_engine_if: command FIFO byte input and draw descriptor output bundle
interface gfx_cmd_decode_engine_if #(
  parameter int COORD_BYTES = 2,
  parameter int COLOR_BITS  = 4
);
  localparam int CW = 8 * COORD_BYTES;
  logic                  cmd_fifo_rts;
  logic [7:0]            cmd_fifo_data;
  logic                  cmd_fifo_rtr;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [CW-1:0]         cmd_origx;
  logic [CW-1:0]         cmd_origy;
  logic [CW-1:0]         cmd_wid;
  logic [CW-1:0]         cmd_hgt;
  logic [COLOR_BITS-1:0] cmd_rval;
  logic [COLOR_BITS-1:0] cmd_gval;
  logic [COLOR_BITS-1:0] cmd_bval;
  logic                  err_illegal_op;
  logic                  busy;
  modport master (
    input  cmd_fifo_rts, cmd_fifo_data, cmd_ready,
    output cmd_fifo_rtr, cmd_valid, cmd_op, cmd_origx, cmd_origy, cmd_wid, cmd_hgt,
           cmd_rval, cmd_gval, cmd_bval, err_illegal_op, busy
  );
  modport slave (
    output cmd_fifo_rts, cmd_fifo_data, cmd_ready,
    input  cmd_fifo_rtr, cmd_valid, cmd_op, cmd_origx, cmd_origy, cmd_wid, cmd_hgt,
           cmd_rval, cmd_gval, cmd_bval, err_illegal_op, busy
  );
endinterface

// File: rtl/gfx_cmd_decode_engine.sv
// gfx_cmd_decode_engine: byte-serial graphics command decoder into a one-deep descriptor register
module gfx_cmd_decode_engine #(
  parameter int COORD_BYTES = 2,
  parameter int COLOR_BITS  = 4
) (
  input logic clk,
  input logic rst,
  gfx_cmd_decode_engine_if.master io_bus
);
  localparam int CW = 8 * COORD_BYTES;
  typedef enum logic [1:0] {S_OPCODE, S_FIELD, S_HOLD} state_t;
  state_t                r_state, w_next;
  logic [1:0]            r_op, r_bcnt, r_cop;
  logic [2:0]            r_fld, w_fld_next;
  logic [CW-1:0]         r_sx, r_sy, r_sw, r_sh, r_cx, r_cy, r_cw, r_ch;
  logic [COLOR_BITS-1:0] r_sr, r_sg, r_sb, r_cr, r_cg, r_cb;
  logic                  r_valid, r_err;
  logic                  w_xfc, w_legal, w_op_go, w_fld_end, w_last, w_free, w_hold_go, w_load;
  logic [7:0]            w_d;
  function automatic logic [CW-1:0] shift_in(input logic [CW-1:0] v, input logic [7:0] b);
    logic [CW+7:0] t;
    t = {v, b};
    return t[CW-1:0];
  endfunction
  assign w_d        = io_bus.cmd_fifo_data;
  assign w_xfc      = io_bus.cmd_fifo_rts && r_state != S_HOLD;
  assign w_legal    = w_d inside {8'h01, 8'h02, 8'h03};
  assign w_op_go    = r_state == S_OPCODE && w_xfc && w_legal;
  assign w_fld_end  = r_fld >= 3'd4 || r_bcnt == 2'(COORD_BYTES - 1);
  assign w_fld_next = (r_fld == 3'd2 && r_op == 2'd2) ? 3'd4 : r_fld + 3'd1;
  assign w_last     = r_state == S_FIELD && w_xfc && r_fld == 3'd6;
  assign w_free     = !r_valid || io_bus.cmd_ready;
  assign w_hold_go  = r_state == S_HOLD && w_free;
  always_comb begin
    w_load = (w_last && w_free) || w_hold_go;
    w_next = w_op_go ? S_FIELD : w_last ? (w_free ? S_OPCODE : S_HOLD) : w_hold_go ? S_OPCODE : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_OPCODE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_op, r_bcnt, r_fld, r_sx, r_sy, r_sw, r_sh, r_sr, r_sg, r_sb} <= '0;
      {r_cop, r_cx, r_cy, r_cw, r_ch, r_cr, r_cg, r_cb, r_valid, r_err} <= '0;
    end else begin
      r_err <= r_state == S_OPCODE && w_xfc && !w_legal;
      if (w_op_go) begin
        r_op   <= w_d[1:0];
        r_fld  <= w_d[1:0] == 2'd3 ? 3'd4 : 3'd0;
        r_bcnt <= '0;
        {r_sx, r_sy, r_sw, r_sh, r_sr, r_sg, r_sb} <= '0;
      end else if (r_state == S_FIELD && w_xfc) begin
        r_bcnt <= w_fld_end ? 2'd0 : r_bcnt + 2'd1;
        if (w_fld_end) r_fld <= w_fld_next;
        if (r_fld == 3'd0) r_sx <= shift_in(r_sx, w_d);
        if (r_fld == 3'd1) r_sy <= shift_in(r_sy, w_d);
        if (r_fld == 3'd2) r_sw <= shift_in(r_sw, w_d);
        if (r_fld == 3'd3) r_sh <= shift_in(r_sh, w_d);
        if (r_fld == 3'd4) r_sr <= w_d[COLOR_BITS-1:0];
        if (r_fld == 3'd5) r_sg <= w_d[COLOR_BITS-1:0];
        if (r_fld == 3'd6) r_sb <= w_d[COLOR_BITS-1:0];
      end
      // a load straight from FIELD carries the blue byte on the bus, not yet in staging
      if (w_load) begin
        r_valid <= 1'b1;
        r_cop   <= r_op;
        r_cx    <= r_op == 2'd3 ? '0 : r_sx;
        r_cy    <= r_op == 2'd3 ? '0 : r_sy;
        r_cw    <= r_op == 2'd3 ? '1 : r_sw;
        r_ch    <= r_op == 2'd3 ? '1 : r_op == 2'd2 ? CW'(1) : r_sh;
        r_cr    <= r_sr;
        r_cg    <= r_sg;
        r_cb    <= r_state == S_FIELD ? w_d[COLOR_BITS-1:0] : r_sb;
      end else if (io_bus.cmd_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign io_bus.cmd_fifo_rtr   = r_state != S_HOLD;
  assign io_bus.cmd_valid      = r_valid;
  assign io_bus.cmd_op         = r_cop;
  assign io_bus.cmd_origx      = r_cx;
  assign io_bus.cmd_origy      = r_cy;
  assign io_bus.cmd_wid        = r_cw;
  assign io_bus.cmd_hgt        = r_ch;
  assign io_bus.cmd_rval       = r_cr;
  assign io_bus.cmd_gval       = r_cg;
  assign io_bus.cmd_bval       = r_cb;
  assign io_bus.err_illegal_op = r_err;
  assign io_bus.busy           = r_state != S_OPCODE;
endmodule

// File: tb/tb_gfx_cmd_decode_engine.sv
// tb_gfx_cmd_decode_engine: directed and scoreboarded checks of the command decoder
module tb_gfx_cmd_decode_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  gfx_cmd_decode_engine_if #(.COORD_BYTES(2), .COLOR_BITS(4)) a ();
  gfx_cmd_decode_engine_if #(.COORD_BYTES(1), .COLOR_BITS(8)) b ();
  gfx_cmd_decode_engine #(.COORD_BYTES(2), .COLOR_BITS(4)) dut_a (.clk(clk), .rst(rst), .io_bus(a.master));
  gfx_cmd_decode_engine #(.COORD_BYTES(1), .COLOR_BITS(8)) dut_b (.clk(clk), .rst(rst), .io_bus(b.master));
  int tests = 0;
  int fails = 0;
  bit rnd = 1'b0;
  bit mon_en = 1'b0;
  int n_seen = 0;
  logic [77:0] exp_q[$];
  logic [77:0] desc_a;
  logic [57:0] desc_b;
  assign desc_a = {a.cmd_op, a.cmd_origx, a.cmd_origy, a.cmd_wid, a.cmd_hgt, a.cmd_rval, a.cmd_gval, a.cmd_bval};
  assign desc_b = {b.cmd_op, b.cmd_origx, b.cmd_origy, b.cmd_wid, b.cmd_hgt, b.cmd_rval, b.cmd_gval, b.cmd_bval};
  logic [7:0] fr [12] = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40, 8'h0F, 8'h08, 8'h03};
  localparam logic [77:0] FR_EXP = {2'd1, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 4'hF, 4'h8, 4'h3};

  always @(posedge clk) begin
    if (mon_en && a.cmd_valid && a.cmd_ready) begin
      tests++;
      n_seen++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_extra: unexpected descriptor %h", desc_a);
      end else begin
        if (desc_a !== exp_q[0]) begin
          fails++;
          $display("FAIL sb_desc #%0d: got %h expected %h", n_seen, desc_a, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_a(input logic [7:0] v);
    logic go;
    for (int i = 0; i < 200; i++) begin
      a.cmd_fifo_rts = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      a.cmd_fifo_data = a.cmd_fifo_rts ? v : 8'($urandom);
      if (rnd) a.cmd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      go = a.cmd_fifo_rtr && a.cmd_fifo_rts;
      @(posedge clk);
      #1;
      if (go) return;
    end
    tests++;
    fails++;
    $display("FAIL send_a_timeout: byte %h not accepted, rtr=%b", v, a.cmd_fifo_rtr);
  endtask

  task automatic send_b(input logic [7:0] v);
    logic go;
    b.cmd_fifo_rts = 1'b1;
    b.cmd_fifo_data = v;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      go = b.cmd_fifo_rtr;
      @(posedge clk);
      #1;
      if (go) return;
    end
    tests++;
    fails++;
    $display("FAIL send_b_timeout: byte %h not accepted", v);
  endtask

  task automatic test_reset;
    a.cmd_fifo_rts = 0; a.cmd_fifo_data = 0; a.cmd_ready = 0;
    b.cmd_fifo_rts = 0; b.cmd_fifo_data = 0; b.cmd_ready = 0;
    #2 rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({a.cmd_valid, a.cmd_fifo_rtr, a.busy, a.err_illegal_op, desc_a} !== {4'b0100, 78'd0}) begin
      fails++;
      $display("FAIL reset_a: v/rtr/busy/err=%b%b%b%b desc=%h, expected 0100 and 0", a.cmd_valid, a.cmd_fifo_rtr, a.busy, a.err_illegal_op, desc_a);
    end
    tests++;
    if ({b.cmd_valid, b.cmd_fifo_rtr, b.busy, desc_b} !== {3'b010, 58'd0}) begin
      fails++;
      $display("FAIL reset_b: v/rtr/busy=%b%b%b desc=%h, expected 010 and 0", b.cmd_valid, b.cmd_fifo_rtr, b.busy, desc_b);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_fill_rect;
    a.cmd_ready = 1;
    for (int i = 0; i < 11; i++) send_a(fr[i]);
    tests++;
    if (a.cmd_valid !== 1'b0 || a.busy !== 1'b1) begin
      fails++;
      $display("FAIL fill_early: valid=%b busy=%b, expected 0 1", a.cmd_valid, a.busy);
    end
    send_a(fr[11]);
    a.cmd_fifo_rts = 0;
    tests++;
    if (a.cmd_valid !== 1'b1 || desc_a !== FR_EXP) begin
      fails++;
      $display("FAIL fill_desc: valid=%b desc=%h, expected 1 %h", a.cmd_valid, desc_a, FR_EXP);
    end
    @(posedge clk);
    #1;
    tests++;
    if (a.cmd_valid !== 1'b0 || a.busy !== 1'b0) begin
      fails++;
      $display("FAIL fill_clear: valid=%b busy=%b, expected 0 0", a.cmd_valid, a.busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [77:0] clr;
    clr = {2'd3, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 4'h1, 4'h2, 4'h3};
    a.cmd_ready = 0;
    for (int i = 0; i < 12; i++) send_a(fr[i]);
    send_a(8'h03); send_a(8'h01); send_a(8'h02);
    tests++;
    if (a.cmd_fifo_rtr !== 1'b1) begin
      fails++;
      $display("FAIL b2b_rtr_early: rtr=%b, expected 1", a.cmd_fifo_rtr);
    end
    send_a(8'h03);
    a.cmd_fifo_rts = 0;
    tests++;
    if ({a.cmd_fifo_rtr, a.busy, a.cmd_valid} !== 3'b011 || desc_a !== FR_EXP) begin
      fails++;
      $display("FAIL b2b_hold: rtr/busy/valid=%b%b%b desc=%h, expected 011 %h", a.cmd_fifo_rtr, a.busy, a.cmd_valid, desc_a, FR_EXP);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (a.cmd_valid !== 1'b1 || desc_a !== FR_EXP || a.cmd_fifo_rtr !== 1'b0) begin
      fails++;
      $display("FAIL b2b_stable: valid=%b rtr=%b desc=%h, expected 1 0 %h", a.cmd_valid, a.cmd_fifo_rtr, desc_a, FR_EXP);
    end
    a.cmd_ready = 1;
    @(posedge clk);
    #1;
    tests++;
    if ({a.cmd_valid, a.cmd_fifo_rtr, a.busy} !== 3'b110 || desc_a !== clr) begin
      fails++;
      $display("FAIL b2b_clear: valid/rtr/busy=%b%b%b desc=%h, expected 110 %h", a.cmd_valid, a.cmd_fifo_rtr, a.busy, desc_a, clr);
    end
    @(posedge clk);
    #1;
    tests++;
    if (a.cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: valid=%b, expected 0", a.cmd_valid);
    end
  endtask

  task automatic test_illegal_op;
    logic [7:0] hl [10] = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h0A, 8'h01, 8'h02, 8'h03};
    logic [77:0] exp;
    exp = {2'd2, 16'd5, 16'd6, 16'd10, 16'd1, 4'h1, 4'h2, 4'h3};
    a.cmd_ready = 1;
    send_a(8'h7E);
    tests++;
    if ({a.err_illegal_op, a.cmd_valid, a.busy} !== 3'b100) begin
      fails++;
      $display("FAIL illegal_pulse: err/valid/busy=%b%b%b, expected 100", a.err_illegal_op, a.cmd_valid, a.busy);
    end
    send_a(hl[0]);
    tests++;
    if (a.err_illegal_op !== 1'b0 || a.busy !== 1'b1) begin
      fails++;
      $display("FAIL illegal_once: err=%b busy=%b, expected 0 1", a.err_illegal_op, a.busy);
    end
    for (int i = 1; i < 10; i++) send_a(hl[i]);
    a.cmd_fifo_rts = 0;
    tests++;
    if (a.cmd_valid !== 1'b1 || desc_a !== exp) begin
      fails++;
      $display("FAIL hline_desc: valid=%b desc=%h, expected 1 %h", a.cmd_valid, desc_a, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset;
    logic [77:0] exp;
    exp = {2'd3, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 4'hA, 4'hB, 4'hC};
    a.cmd_ready = 1;
    send_a(8'h01); send_a(8'h00); send_a(8'h10); send_a(8'h00); send_a(8'h20);
    a.cmd_fifo_rts = 0;
    tests++;
    if (a.busy !== 1'b1 || a.cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_pre: busy=%b valid=%b, expected 1 0", a.busy, a.cmd_valid);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({a.cmd_valid, a.cmd_fifo_rtr, a.busy, a.err_illegal_op, desc_a} !== {4'b0100, 78'd0}) begin
      fails++;
      $display("FAIL midrst_async: v/rtr/busy/err=%b%b%b%b desc=%h, expected 0100 and 0", a.cmd_valid, a.cmd_fifo_rtr, a.busy, a.err_illegal_op, desc_a);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    send_a(8'h03); send_a(8'h0A); send_a(8'h0B);
    tests++;
    if (a.cmd_valid !== 1'b0 || a.err_illegal_op !== 1'b0) begin
      fails++;
      $display("FAIL midrst_partial: valid=%b err=%b, expected 0 0", a.cmd_valid, a.err_illegal_op);
    end
    send_a(8'h0C);
    a.cmd_fifo_rts = 0;
    tests++;
    if (a.cmd_valid !== 1'b1 || desc_a !== exp) begin
      fails++;
      $display("FAIL midrst_clear: valid=%b desc=%h, expected 1 %h", a.cmd_valid, desc_a, exp);
    end
    @(posedge clk);
    #1;
    tests++;
    if (a.cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_drain: valid=%b, expected 0", a.cmd_valid);
    end
  endtask

  task automatic test_narrow_params;
    logic [7:0] nb [8] = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC};
    logic [57:0] exp;
    exp = {2'd1, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC};
    b.cmd_ready = 1;
    for (int i = 0; i < 8; i++) send_b(nb[i]);
    b.cmd_fifo_rts = 0;
    tests++;
    if (b.cmd_valid !== 1'b1 || desc_b !== exp) begin
      fails++;
      $display("FAIL narrow_desc: valid=%b desc=%h, expected 1 %h", b.cmd_valid, desc_b, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_stream;
    logic [1:0]  op;
    logic [15:0] x, y, w, h;
    logic [7:0]  cr, cg, cb;
    mon_en = 1'b1;
    n_seen = 0;
    rnd = 1'b1;
    for (int k = 0; k < 100; k++) begin
      op = 2'($urandom_range(1, 3));
      x = 16'($urandom); y = 16'($urandom); w = 16'($urandom); h = 16'($urandom);
      cr = 8'($urandom); cg = 8'($urandom); cb = 8'($urandom);
      if (op == 2'd3) exp_q.push_back({op, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, cr[3:0], cg[3:0], cb[3:0]});
      else if (op == 2'd2) exp_q.push_back({op, x, y, w, 16'd1, cr[3:0], cg[3:0], cb[3:0]});
      else exp_q.push_back({op, x, y, w, h, cr[3:0], cg[3:0], cb[3:0]});
      send_a({6'd0, op});
      if (op != 2'd3) begin
        send_a(x[15:8]); send_a(x[7:0]); send_a(y[15:8]); send_a(y[7:0]); send_a(w[15:8]); send_a(w[7:0]);
      end
      if (op == 2'd1) begin
        send_a(h[15:8]); send_a(h[7:0]);
      end
      send_a(cr); send_a(cg); send_a(cb);
    end
    rnd = 1'b0;
    a.cmd_fifo_rts = 0;
    a.cmd_ready = 1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    mon_en = 1'b0;
    tests++;
    if (n_seen != 100 || exp_q.size() != 0 || a.cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL random_count: seen=%0d left=%0d valid=%b, expected 100 0 0", n_seen, exp_q.size(), a.cmd_valid);
    end
  endtask

  initial begin
    test_reset;
    test_fill_rect;
    test_back_to_back;
    test_illegal_op;
    test_mid_reset;
    test_narrow_params;
    test_random_stream;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
